// File: rtl/fb_pkg.sv
// Shared definitions for the frame buffer: page geometry, address widths and the
// write-controller state encoding.
package fb_pkg;

  localparam int FB_PAGE_BYTES = 1024;
  localparam int FB_BYTE_AW    = 11;
  localparam int FB_WORD_AW    = 9;
  localparam int FB_IDX_W      = FB_BYTE_AW - 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    WAIT_SWAP = 2'd2
  } fb_state_e;

endpackage

// File: rtl/fb_write_ctrl.sv
// Fills the back page of a two-page frame buffer from a byte stream; swaps pages on vsync.
// Writes are registered (1 cycle after transfer); s_ready drops while a full frame waits for vsync.
module fb_write_ctrl
  import fb_pkg::*;
#(
  parameter int FRAME_BYTES = FB_PAGE_BYTES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  input  logic                  s_sof,
  output logic                  s_ready,
  input  logic                  vsync,
  output logic                  ram_we,
  output logic [FB_BYTE_AW-1:0] ram_addr,
  output logic [7:0]            ram_din,
  output logic                  disp_page,
  output logic                  frame_done,
  output logic                  err
);

  localparam logic [FB_IDX_W-1:0] LAST_IDX = FB_IDX_W'(FRAME_BYTES - 1);

  fb_state_e             state_q, state_d;
  logic [FB_IDX_W-1:0]   cnt_q, cnt_d;
  logic                  disp_page_q, disp_page_d;
  logic                  ram_we_q, ram_we_d;
  logic [FB_BYTE_AW-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]            ram_din_q, ram_din_d;
  logic                  frame_done_q, frame_done_d;
  logic                  err_q, err_d;
  logic                  xfer;

  assign s_ready = (state_q != WAIT_SWAP);
  assign xfer    = s_valid && s_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    disp_page_d  = disp_page_q;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    frame_done_d = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (s_sof) begin
            ram_we_d   = 1'b1;
            ram_addr_d = {~disp_page_q, {FB_IDX_W{1'b0}}};
            ram_din_d  = s_data;
            cnt_d      = FB_IDX_W'(1);
            state_d    = FILL;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      FILL: begin
        if (xfer) begin
          ram_we_d  = 1'b1;
          ram_din_d = s_data;
          if (s_sof) begin
            // Restart: the partial frame is abandoned in place and overwritten.
            err_d      = 1'b1;
            ram_addr_d = {~disp_page_q, {FB_IDX_W{1'b0}}};
            cnt_d      = FB_IDX_W'(1);
          end else begin
            ram_addr_d = {~disp_page_q, cnt_q};
            if (cnt_q == LAST_IDX) begin
              cnt_d   = '0;
              state_d = WAIT_SWAP;
            end else begin
              cnt_d = cnt_q + FB_IDX_W'(1);
            end
          end
        end
      end

      WAIT_SWAP: begin
        if (vsync) begin
          disp_page_d  = ~disp_page_q;
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      disp_page_q  <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      disp_page_q  <= disp_page_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_din    = ram_din_q;
  assign disp_page  = disp_page_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule
